// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencing arbiter:
// FSM states, interval-timer register map and the timer write-bus payload.
package timer_seq_pkg;

   localparam int unsigned PERIOD_W   = 32;
   localparam int unsigned TMR_ADDR_W = 3;
   localparam int unsigned TMR_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WR_PL,
      WR_PH,
      WR_CTRL,
      WAIT_IRQ,
      WR_STOP,
      CLR_STAT,
      DONE
   } state_t;

   localparam logic [TMR_ADDR_W-1:0] ADDR_STATUS   = 3'd0;
   localparam logic [TMR_ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
   localparam logic [TMR_ADDR_W-1:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [TMR_ADDR_W-1:0] ADDR_PERIOD_H = 3'd3;

   localparam logic [TMR_DATA_W-1:0] CTRL_ITO   = 16'h0001;
   localparam logic [TMR_DATA_W-1:0] CTRL_CONT  = 16'h0002;
   localparam logic [TMR_DATA_W-1:0] CTRL_START = 16'h0004;
   localparam logic [TMR_DATA_W-1:0] CTRL_STOP  = 16'h0008;

   typedef struct packed {
      logic                  chipselect;
      logic                  write_n;
      logic [TMR_ADDR_W-1:0] address;
      logic [TMR_DATA_W-1:0] writedata;
   } tmr_bus_t;

   localparam tmr_bus_t TMR_BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1,
                                         address: '0, writedata: '0};

   // Timer write issued while the FSM sits in state s.
   function automatic tmr_bus_t tmr_cmd(input state_t s, input logic [PERIOD_W-1:0] period);
      tmr_bus_t b;
      b = TMR_BUS_IDLE;
      case (s)
         WR_PL:    b = '{1'b1, 1'b0, ADDR_PERIOD_L, period[15:0]};
         WR_PH:    b = '{1'b1, 1'b0, ADDR_PERIOD_H, period[31:16]};
         WR_CTRL:  b = '{1'b1, 1'b0, ADDR_CONTROL, (CTRL_START | CTRL_ITO) & ~CTRL_CONT};
         WR_STOP:  b = '{1'b1, 1'b0, ADDR_CONTROL, CTRL_STOP};
         CLR_STAT: b = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000};
         default:  b = TMR_BUS_IDLE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requester at or after ptr (wrapping) wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index
);

   int unsigned j;

   // Scan farthest-first so the nearest asserted requester overwrites last.
   always_comb begin
      grant = '0;
      index = '0;
      j     = 0;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
         j = (int'(ptr) + off) % NUM_REQ;
         if (req[IDX_W'(j)]) begin
            grant = NUM_REQ'(1) << j;
            index = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/timer_seq_arbiter.sv
// Arbitrates timeout jobs from NUM_REQ requesters onto one interval timer,
// sequencing period/control/status writes and reporting completion per requester.
module timer_seq_arbiter
   import timer_seq_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_period,
   input  logic [NUM_REQ-1:0]      req_cancel,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      done,
   output logic                    busy,
   output logic [TMR_ADDR_W-1:0]   tmr_address,
   output logic                    tmr_chipselect,
   output logic                    tmr_write_n,
   output logic [TMR_DATA_W-1:0]   tmr_writedata,
   input  logic                    tmr_irq
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state, next_state;
   logic [IDX_W-1:0]    ptr, job_idx, gnt_idx, eff_idx;
   logic [NUM_REQ-1:0]  gnt_vec, done_d;
   logic [PERIOD_W-1:0] job_period, eff_period;
   logic [PERIOD_W-1:0] periods [NUM_REQ];
   logic                accept, cancelled, busy_d;
   tmr_bus_t            bus_q, bus_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_period
      assign periods[g] = req_period[g*PERIOD_W +: PERIOD_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (gnt_vec),
      .index (gnt_idx)
   );

   // On the accept cycle the job registers are not loaded yet, so bypass them.
   assign accept     = (state == IDLE) && (|req_valid);
   assign eff_idx    = accept ? gnt_idx : job_idx;
   assign eff_period = accept ? periods[gnt_idx] : job_period;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (accept) next_state = (eff_period == '0) ? DONE : WR_PL;
         WR_PL:    next_state = WR_PH;
         WR_PH:    next_state = WR_CTRL;
         WR_CTRL:  next_state = WAIT_IRQ;
         WAIT_IRQ: begin
            if (tmr_irq)                  next_state = CLR_STAT;
            else if (req_cancel[job_idx]) next_state = WR_STOP;
         end
         WR_STOP:  next_state = CLR_STAT;
         CLR_STAT: next_state = cancelled ? IDLE : DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Registered outputs are precomputed from next_state so they line up with the state.
   always_comb begin
      bus_d     = tmr_cmd(next_state, eff_period);
      done_d    = '0;
      busy_d    = (next_state != IDLE);
      req_ready = '0;
      if (next_state == DONE) done_d = NUM_REQ'(1) << eff_idx;
      if (accept && reset_n)  req_ready = gnt_vec;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr        <= '0;
         job_idx    <= '0;
         job_period <= '0;
         cancelled  <= 1'b0;
         bus_q      <= TMR_BUS_IDLE;
         done       <= '0;
         busy       <= 1'b0;
      end else begin
         bus_q <= bus_d;
         done  <= done_d;
         busy  <= busy_d;
         if (accept) begin
            job_idx    <= gnt_idx;
            job_period <= eff_period;
            cancelled  <= 1'b0;
            ptr        <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
         end
         if (state == WAIT_IRQ && next_state == WR_STOP) cancelled <= 1'b1;
      end
   end

   assign tmr_chipselect = bus_q.chipselect;
   assign tmr_write_n    = bus_q.write_n;
   assign tmr_address    = bus_q.address;
   assign tmr_writedata  = bus_q.writedata;

endmodule

// File: tb/tb_timer_seq_arbiter.sv
// Bench for timer_seq_arbiter: timeline scoreboard checked every cycle plus
// directed scenarios with literal expectations.
module tb_timer_seq_arbiter;

   localparam int N   = 4;
   localparam int INF = 32'h7fff_ffff;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*32-1:0] req_period = '0;
   logic [N-1:0]    req_cancel = '0;
   logic            tmr_irq = 1'b0;
   logic [N-1:0]    req_ready, done;
   logic            busy, tmr_chipselect, tmr_write_n;
   logic [2:0]      tmr_address;
   logic [15:0]     tmr_writedata;

   always #5 clk = ~clk;

   timer_seq_arbiter #(.NUM_REQ(N)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_period     (req_period),
      .req_cancel     (req_cancel),
      .req_ready      (req_ready),
      .done           (done),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Timeline model: each accepted job schedules its bus writes and done pulse by cycle number.
   int          m_ptr = 0, m_free_at = 0, m_wait_from = INF, m_job = 0;
   int          m_busy_from = 1, m_busy_end = 0, m_w;
   bit          m_waiting = 0;
   logic [31:0] m_p;
   int          m_addr [int];
   int          m_data [int];
   int          m_done [int];
   logic [N-1:0] e_ready, e_done;
   logic         e_busy, e_cs, e_wn;
   int           e_addr, e_data;

   always @(negedge clk) begin
      e_ready = '0;
      if (!reset_n) begin
         m_ptr = 0; m_free_at = 0; m_waiting = 0; m_wait_from = INF;
         m_busy_from = 1; m_busy_end = 0;
         m_addr.delete(); m_data.delete(); m_done.delete();
      end else if (cyc >= m_free_at && req_valid != '0) begin
         m_w = -1;
         for (int k = 0; k < N; k++)
            if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
         e_ready[m_w] = 1'b1;
         m_job = m_w;
         m_ptr = (m_w + 1) % N;
         m_p = req_period[m_w*32 +: 32];
         m_busy_from = cyc + 1;
         if (m_p == 0) begin
            m_done[cyc+1] = m_w;
            m_busy_end = cyc + 1;
            m_free_at  = cyc + 2;
         end else begin
            m_addr[cyc+1] = 2; m_data[cyc+1] = int'(m_p[15:0]);
            m_addr[cyc+2] = 3; m_data[cyc+2] = int'(m_p[31:16]);
            m_addr[cyc+3] = 1; m_data[cyc+3] = 5;
            m_waiting = 1; m_wait_from = cyc + 4;
            m_busy_end = INF; m_free_at = INF;
         end
      end else if (m_waiting && cyc >= m_wait_from) begin
         if (tmr_irq) begin
            m_addr[cyc+1] = 0; m_data[cyc+1] = 0;
            m_done[cyc+2] = m_job;
            m_busy_end = cyc + 2; m_free_at = cyc + 3; m_waiting = 0;
         end else if (req_cancel[m_job]) begin
            m_addr[cyc+1] = 1; m_data[cyc+1] = 8;
            m_addr[cyc+2] = 0; m_data[cyc+2] = 0;
            m_busy_end = cyc + 2; m_free_at = cyc + 3; m_waiting = 0;
         end
      end

      e_cs = 1'b0; e_wn = 1'b1; e_addr = 0; e_data = 0; e_done = '0; e_busy = 1'b0;
      if (reset_n) begin
         if (m_addr.exists(cyc)) begin
            e_cs = 1'b1; e_wn = 1'b0; e_addr = m_addr[cyc]; e_data = m_data[cyc];
         end
         if (m_done.exists(cyc)) e_done[m_done[cyc]] = 1'b1;
         e_busy = (cyc >= m_busy_from) && (cyc <= m_busy_end);
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("tmr_chipselect", 32'(tmr_chipselect), 32'(e_cs));
      chk("tmr_write_n", 32'(tmr_write_n), 32'(e_wn));
      chk("tmr_address", 32'(tmr_address), e_addr);
      chk("tmr_writedata", 32'(tmr_writedata), e_data);
   end

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
   endtask

   // Wait (bounded) for an accept pulse, require it to be requester i, then drop its valid.
   task automatic wait_ready(input int i);
      bit seen;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            seen = 1;
            chk($sformatf("grant_order_%0d", i), 32'(req_ready), 32'(1) << i);
         end
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL ready_timeout req=%0d actual=none required=pulse", i);
      end
      @(posedge clk); #1 req_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      bit seen;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done != '0) begin
            seen = 1;
            chk($sformatf("done_%0d", i), 32'(done), 32'(1) << i);
         end
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout req=%0d actual=none required=pulse", i);
      end
   endtask

   initial begin
      #1 reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

      // Single job on requester 0 with literal bus trace.
      req_period[31:0] = 32'h0001_0002;
      req_valid = 4'b0001;
      @(negedge clk); chk("t1_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); chk("t1_pl_addr", 32'(tmr_address), 2); chk("t1_pl_data", 32'(tmr_writedata), 32'h2);
      chk("t1_pl_cs", 32'(tmr_chipselect), 1); chk("t1_pl_wn", 32'(tmr_write_n), 0);
      @(negedge clk); chk("t1_ph_addr", 32'(tmr_address), 3); chk("t1_ph_data", 32'(tmr_writedata), 32'h1);
      @(negedge clk); chk("t1_ctrl_addr", 32'(tmr_address), 1); chk("t1_ctrl_data", 32'(tmr_writedata), 32'h5);
      @(negedge clk); chk("t1_wait_cs", 32'(tmr_chipselect), 0); chk("t1_wait_busy", 32'(busy), 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 tmr_irq = 1'b1;
      @(posedge clk); #1 tmr_irq = 1'b0;
      @(negedge clk); chk("t1_clr_addr", 32'(tmr_address), 0); chk("t1_clr_cs", 32'(tmr_chipselect), 1);
      @(negedge clk); chk("t1_done", 32'(done), 32'h1);
      @(negedge clk); chk("t1_idle_busy", 32'(busy), 0); chk("t1_idle_done", 32'(done), 0);

      // All four requesters from reset: served 0,1,2,3.
      do_reset();
      req_period = {32'h0000_0005, 32'h0002_0000, 32'h0000_0010, 32'h0000_0003};
      req_valid  = 4'b1111;
      for (int k = 0; k < N; k++) begin
         wait_ready(k);
         repeat (3) @(posedge clk);
         #1 tmr_irq = 1'b1;
         @(posedge clk); #1 tmr_irq = 1'b0;
         wait_done(k);
      end

      // Zero period on requester 2: done the next cycle, no timer access.
      @(posedge clk); #1;
      req_period[95:64] = 32'h0;
      req_valid = 4'b0100;
      @(negedge clk); chk("t3_ready", 32'(req_ready), 32'h4); chk("t3_cs0", 32'(tmr_chipselect), 0);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); chk("t3_done", 32'(done), 32'h4); chk("t3_cs1", 32'(tmr_chipselect), 0);

      // Cancel on requester 1, with ignored cancels first.
      @(posedge clk); #1;
      req_period[63:32] = 32'h0000_0100;
      req_valid = 4'b0010;
      wait_ready(1);
      req_cancel[1] = 1'b1;
      @(posedge clk); #1 req_cancel = '0;
      repeat (2) @(posedge clk);
      #1 req_cancel[0] = 1'b1;
      @(posedge clk); #1 req_cancel = 4'b0010;
      @(posedge clk); #1 req_cancel = '0;
      @(negedge clk); chk("t4_stop_addr", 32'(tmr_address), 1); chk("t4_stop_data", 32'(tmr_writedata), 32'h8);
      @(negedge clk); chk("t4_clr_addr", 32'(tmr_address), 0); chk("t4_clr_data", 32'(tmr_writedata), 0);
      @(negedge clk); chk("t4_busy", 32'(busy), 0); chk("t4_no_done", 32'(done), 0);

      // irq and cancel together: irq wins.
      @(posedge clk); #1;
      req_period[127:96] = 32'h0000_0007;
      req_valid = 4'b1000;
      wait_ready(3);
      repeat (3) @(posedge clk);
      #1 tmr_irq = 1'b1; req_cancel[3] = 1'b1;
      @(posedge clk); #1 tmr_irq = 1'b0; req_cancel = '0;
      @(negedge clk); chk("t5_clr_addr", 32'(tmr_address), 0); chk("t5_clr_data", 32'(tmr_writedata), 0);
      @(negedge clk); chk("t5_done", 32'(done), 32'h8);

      // Reset while writing period_h.
      @(posedge clk); #1;
      req_period[63:32] = 32'h0000_0055;
      req_period[31:0]  = 32'h0000_0009;
      req_valid = 4'b0010;
      wait_ready(1);
      @(posedge clk); #1;
      chk("t6_in_ph", 32'(tmr_address), 3);
      req_valid = 4'b1111;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_cs", 32'(tmr_chipselect), 0); chk("t6_rst_wn", 32'(tmr_write_n), 1);
      chk("t6_rst_addr", 32'(tmr_address), 0); chk("t6_rst_data", 32'(tmr_writedata), 0);
      chk("t6_rst_busy", 32'(busy), 0); chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_ready", 32'(req_ready), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk); chk("t6_ptr0_grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1 tmr_irq = 1'b1;
      @(posedge clk); #1 tmr_irq = 1'b0;
      wait_done(0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
